// File: rtl/cu_mem_stage.sv
// MEM-stage control unit: decodes the EX opcode, runs one load/store at a time on the
// data-memory handshake, stalls upstream while waiting, and registers the WB controls.
module cu_mem_stage #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [6:0]    ex_opcode,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          flush,
  output logic          stall_out,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_err,
  output logic          wb_valid,
  output logic [6:0]    wb_opcode,
  output logic [DW-1:0] wb_data,
  output logic          wb_reg_write,
  output logic          wb_mem_to_reg
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [6:0]    r_op, w_op_next;
  logic          r_mem_req, w_mem_req_next;
  logic          r_mem_we, w_mem_we_next;
  logic [AW-1:0] r_mem_addr, w_mem_addr_next;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_next;
  logic          r_mem_err, w_mem_err_next;
  logic          r_wb_valid, w_wb_valid_next;
  logic [6:0]    r_wb_opcode, w_wb_opcode_next;
  logic [DW-1:0] r_wb_data, w_wb_data_next;
  logic          r_wb_rw, w_wb_rw_next;
  logic          r_wb_m2r, w_wb_m2r_next;

  logic w_is_mem, w_is_rw, w_is_known, w_accept;

  always_comb begin
    w_is_mem = (ex_opcode == OPC_LOAD) || (ex_opcode == OPC_STORE);
    w_is_rw  = (ex_opcode == OPC_OP)  || (ex_opcode == OPC_OPIMM) ||
               (ex_opcode == OPC_LUI) || (ex_opcode == OPC_AUIPC) ||
               (ex_opcode == OPC_JAL) || (ex_opcode == OPC_JALR);
    w_is_known = w_is_mem || w_is_rw || (ex_opcode == OPC_BRANCH);
    w_accept   = ex_valid && !flush && w_is_known;
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_op_next        = r_op;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_err_next   = 1'b0;
    w_wb_valid_next  = 1'b0;
    w_wb_opcode_next = 7'b0000000;
    w_wb_data_next   = '0;
    w_wb_rw_next     = 1'b0;
    w_wb_m2r_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_mem_req_next = 1'b0;
        if (w_accept) begin
          if (w_is_mem) begin
            w_op_next        = ex_opcode;
            w_mem_req_next   = 1'b1;
            w_mem_we_next    = (ex_opcode == OPC_STORE);
            w_mem_addr_next  = ex_addr;
            w_mem_wdata_next = ex_wdata;
            w_cnt_next       = '0;
            w_state_next     = S_WAIT_ACK;
          end else begin
            w_wb_valid_next  = 1'b1;
            w_wb_opcode_next = ex_opcode;
            w_wb_data_next   = ex_wdata;
            w_wb_rw_next     = w_is_rw;
          end
        end
      end
      S_WAIT_ACK: begin
        w_cnt_next = r_cnt + 1'b1;
        // ack is checked first so a same-cycle ack beats the timeout
        if (mem_ack) begin
          w_mem_req_next   = 1'b0;
          w_wb_valid_next  = 1'b1;
          w_wb_opcode_next = r_op;
          if (!r_mem_we) begin
            w_wb_data_next = mem_rdata;
            w_wb_rw_next   = 1'b1;
            w_wb_m2r_next  = 1'b1;
          end
          w_state_next = S_IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_mem_req_next = 1'b0;
          w_mem_err_next = 1'b1;
          w_state_next   = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_err   <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_opcode <= '0;
      r_wb_data   <= '0;
      r_wb_rw     <= 1'b0;
      r_wb_m2r    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_op        <= w_op_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_err   <= w_mem_err_next;
      r_wb_valid  <= w_wb_valid_next;
      r_wb_opcode <= w_wb_opcode_next;
      r_wb_data   <= w_wb_data_next;
      r_wb_rw     <= w_wb_rw_next;
      r_wb_m2r    <= w_wb_m2r_next;
    end
  end

  assign stall_out     = (r_state == S_WAIT_ACK);
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_err       = r_mem_err;
  assign wb_valid      = r_wb_valid;
  assign wb_opcode     = r_wb_opcode;
  assign wb_data       = r_wb_data;
  assign wb_reg_write  = r_wb_rw;
  assign wb_mem_to_reg = r_wb_m2r;

endmodule

// File: tb/tb_cu_mem_stage.sv
// Scoreboard bench for cu_mem_stage: stimulus pushes expected WB records, a monitor
// process pops and compares them whenever wb_valid is seen.
module tb_cu_mem_stage;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011;

  logic          clk = 1'b1;
  logic          reset = 1'b1;
  logic          ex_valid = 0;
  logic [6:0]    ex_opcode = 0;
  logic [AW-1:0] ex_addr = 0;
  logic [DW-1:0] ex_wdata = 0;
  logic          flush = 0;
  logic          stall_out, mem_req, mem_we, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 0;
  logic [DW-1:0] mem_rdata = 0;
  logic          wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [6:0]    wb_opcode;
  logic [DW-1:0] wb_data;

  cu_mem_stage #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush), .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err), .wb_valid(wb_valid),
    .wb_opcode(wb_opcode), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]    op;
    logic [DW-1:0] data;
    logic          rw;
    logic          m2r;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int err_expected = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  // Monitor: sample away from the active (negative) edge
  always @(posedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wb_unexpected: got op=0x%0h data=0x%0h required no WB instruction",
                   wb_opcode, wb_data);
        end else begin
          wb_exp_t e;
          e = exp_q.pop_front();
          if (wb_opcode !== e.op || wb_data !== e.data ||
              wb_reg_write !== e.rw || wb_mem_to_reg !== e.m2r) begin
            n_bad++;
            $display("FAIL wb_record: got op=0x%0h data=0x%0h rw=%0b m2r=%0b required op=0x%0h data=0x%0h rw=%0b m2r=%0b",
                     wb_opcode, wb_data, wb_reg_write, wb_mem_to_reg, e.op, e.data, e.rw, e.m2r);
          end else
            $display("ok   wb_record: op=0x%0h data=0x%0h rw=%0b m2r=%0b",
                     wb_opcode, wb_data, wb_reg_write, wb_mem_to_reg);
        end
      end
      if (mem_err) begin
        n_cmp++;
        if (err_expected == 0) begin
          n_bad++;
          $display("FAIL mem_err_unexpected: got 1 required 0");
        end else begin
          err_expected--;
          $display("ok   mem_err pulse");
        end
      end
    end
  end

  task automatic push_exp(input logic [6:0] op, input logic [DW-1:0] data,
                          input logic rw, input logic m2r);
    wb_exp_t e;
    e.op = op; e.data = data; e.rw = rw; e.m2r = m2r;
    exp_q.push_back(e);
  endtask

  // Present one instruction for one negedge; caller is positioned just after a negedge
  task automatic issue(input logic v, input logic [6:0] op, input logic [DW-1:0] d,
                       input logic fl);
    ex_valid = v; ex_opcode = op; ex_wdata = d; ex_addr = 32'h0; flush = fl;
    @(negedge clk); #1;
    ex_valid = 0; flush = 0;
  endtask

  // Memory transaction; ack_cyc = WAIT_ACK cycle carrying mem_ack (0 = never)
  task automatic mem_txn(input string name, input logic [6:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ack_cyc,
                         input logic [DW-1:0] rdata, input int exp_stall);
    int k;
    bit hold_ok;
    k = 0;
    hold_ok = 1;
    if (ack_cyc == 0) err_expected++;
    else if (op == LOAD) push_exp(LOAD, rdata, 1'b1, 1'b1);
    else push_exp(STORE, '0, 1'b0, 1'b0);
    ex_valid = 1; ex_opcode = op; ex_addr = a; ex_wdata = d; flush = 0;
    @(negedge clk); #1;
    // upstream noise during the wait must be ignored
    ex_valid = 1; ex_opcode = OPR; ex_addr = 32'hDEAD; ex_wdata = 32'h7777; flush = 1;
    mem_ack = (ack_cyc == 1); mem_rdata = rdata;
    while (k < 2 * TIMEOUT + 4) begin
      @(posedge clk);
      if (!stall_out) break;
      k++;
      if (mem_req !== 1'b1 || mem_addr !== a || mem_wdata !== d || mem_we !== (op == STORE))
        hold_ok = 0;
      @(negedge clk); #1;
      mem_ack = (k + 1 == ack_cyc);
    end
    ex_valid = 0; flush = 0; mem_ack = 0;
    check({name, "_stall_cycles"}, 64'(k), 64'(exp_stall));
    check({name, "_req_held"}, 64'(hold_ok), 64'd1);
    check({name, "_req_dropped"}, 64'(mem_req), 64'd0);
    check({name, "_mem_err"}, 64'(mem_err), 64'(ack_cyc == 0));
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] d;
    logic        v;
    logic        fl;
    logic        exp_wb;
    logic        rw;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{7'b0110011, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{7'b0010011, 32'h0000_0055, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{7'b0110111, 32'hABCD_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{7'b0010111, 32'h1000_0004, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{7'b1101111, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{7'b1100111, 32'h0000_0208, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{7'b1100011, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{7'b1111111, 32'h0000_0999, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{7'b0110011, 32'h0000_0777, 1'b0, 1'b0, 1'b0, 1'b0};

    #2;
    check("reset_outputs",
          {mem_req, mem_we, mem_err, wb_valid, wb_reg_write, wb_mem_to_reg, stall_out,
           wb_opcode, 32'(wb_data)}, 64'd0);
    @(negedge clk); #1;
    reset = 0;

    // First directed vector: ALU op, one-edge latency, no stall
    push_exp(OPR, 32'h1234, 1'b1, 1'b0);
    issue(1'b1, OPR, 32'h1234, 1'b0);
    check("alu_stall_out", 64'(stall_out), 64'd0);
    check("alu_wb_opcode_direct", 64'(wb_opcode), 64'h33);

    foreach (vecs[i]) begin
      if (vecs[i].exp_wb) push_exp(vecs[i].op, vecs[i].d, vecs[i].rw, 1'b0);
      issue(vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].fl);
    end

    // Flush squashes an ALU op and a LOAD presented in IDLE
    issue(1'b1, OPR, 32'h5151, 1'b1);
    ex_addr = 32'h40;
    issue(1'b1, LOAD, 32'h0, 1'b1);
    check("flush_load_no_req", 64'({mem_req, stall_out}), 64'd0);

    mem_txn("load_ack3", LOAD, 32'h40, 32'h0, 3, 32'hCAFE, 3);
    mem_txn("store_timeout", STORE, 32'h80, 32'hBEEF, 0, 32'h0, TIMEOUT);
    mem_txn("store_ack2", STORE, 32'h84, 32'h1111, 2, 32'h0, 2);
    mem_txn("load_ack_tm1", LOAD, 32'h44, 32'h0, TIMEOUT - 1, 32'h5A5A, TIMEOUT - 1);
    mem_txn("load_ack_tm", LOAD, 32'h48, 32'h0, TIMEOUT, 32'h0BAD, TIMEOUT);

    // Stray ack while IDLE
    mem_ack = 1; mem_rdata = 32'hFFFF;
    @(negedge clk); #1;
    @(negedge clk); #1;
    mem_ack = 0;
    check("stray_ack_idle", 64'({mem_req, stall_out, wb_valid, mem_err}), 64'd0);

    // Async reset mid-transaction drops mem_req immediately
    ex_valid = 1; ex_opcode = LOAD; ex_addr = 32'h90;
    @(negedge clk); #1;
    ex_valid = 0;
    @(posedge clk);
    check("pre_reset_req", 64'({mem_req, stall_out}), 64'b11);
    #2 reset = 1;
    #1 check("async_reset_mid_txn", 64'({mem_req, stall_out, mem_we, wb_valid}), 64'd0);
    @(negedge clk); #1;
    reset = 0;

    // Async reset clears a live WB record
    push_exp(OPR, 32'h4242, 1'b1, 1'b0);
    issue(1'b1, OPR, 32'h4242, 1'b0);
    @(posedge clk);
    #2 reset = 1;
    #1 check("async_reset_wb", 64'({wb_valid, wb_reg_write, wb_opcode, 32'(wb_data)}), 64'd0);
    @(negedge clk); #1;
    reset = 0;

    // Recovery after reset
    push_exp(7'b0010011, 32'h0000_00AA, 1'b1, 1'b0);
    issue(1'b1, 7'b0010011, 32'hAA, 1'b0);
    @(posedge clk); #1;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("mem_err_all_seen", 64'(err_expected), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
